ex_muldiv: RTL and testbench

Multi-cycle RV32M execute unit. It sits beside the single-cycle ALU in the EX stage and runs MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It is parametrised in data width and multiplier mode. While an operation is in flight it holds the pipeline through ctrl, then returns one register write-back.

---
 rtl/ex_muldiv_pkg.sv | 34 +++
 rtl/ex_muldiv_if.sv | 30 +++
 rtl/ex_muldiv_div_iter.sv | 28 ++
 rtl/ex_muldiv.sv | 207 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - func3 codes of the M extension and the func7 that selects it
//   - FSM state type
//   - helpers deciding which operands are interpreted as signed
package ex_muldiv_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [6:0] INST_FUNC7_M = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic op1_is_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_MULHSU) ||
           (op == INST_DIV)  || (op == INST_REM);
  endfunction

  function automatic logic op2_is_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_DIV) || (op == INST_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage request / write-back bundle of the multiply/divide unit.
//   Request  : start_i, op_i (func3), op1_i, op2_i, rd_addr_i, flush_i
//   Response : hold_flag_o, busy_o, rd_addr_o, rd_data_o, rd_wen_o
//   master = pipeline side, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              start_i;
  logic [2:0]        op_i;
  logic [XLEN-1:0]   op1_i;
  logic [XLEN-1:0]   op2_i;
  logic [REG_AW-1:0] rd_addr_i;
  logic              flush_i;
  logic              hold_flag_o;
  logic              busy_o;
  logic [REG_AW-1:0] rd_addr_o;
  logic [XLEN-1:0]   rd_data_o;
  logic              rd_wen_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  hold_flag_o, busy_o, rd_addr_o, rd_data_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    output hold_flag_o, busy_o, rd_addr_o, rd_data_o, rd_wen_o
  );
endinterface

// File: rtl/ex_muldiv_div_iter.sv
// div_iter: one step of an unsigned restoring divide (combinational).
//   rem_i / quo_i : partial remainder and dividend-shifting quotient register
//   div_i         : divisor magnitude
//   rem_o / quo_o : values after shifting in the next dividend bit and
//                   conditionally subtracting the divisor
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            ge;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - (XLEN+2)'(div_i);
    ge      = (shifted >= (XLEN+2)'(div_i));
    rem_o   = (XLEN+1)'(ge ? diff : shifted);
    quo_o   = {quo_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) sitting beside the EX-stage ALU.
//   clk, rst (async, active-low)
//   bus (slave): request from id_ex, hold/busy to ctrl, one-cycle write-back.
// Parameters: XLEN datapath width, MUL_ITER (0 = single-cycle multiply,
// 1 = XLEN-cycle shift-add), REG_AW register address width.
// Signed operations run on magnitudes; the sign is restored in the last step.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_ITER = 0,
  parameter int REG_AW   = 5
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  md_state_e           state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN:0]       rem_q, rem_d;

  logic [XLEN-1:0]     op1, op2;
  logic                sign1, sign2;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                is_mul, div_zero, div_ovf;
  logic [2*XLEN-1:0]   prod_full;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_nx;
  logic [XLEN-1:0]     quo_nx;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_mag, rem_fix;
  logic                hold;
  logic [XLEN-1:0]     result;

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (b_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  // Operand decode and single-cycle results.
  always_comb begin
    op1       = bus.op1_i;
    op2       = bus.op2_i;
    sign1     = op1_is_signed(bus.op_i) & op1[XLEN-1];
    sign2     = op2_is_signed(bus.op_i) & op2[XLEN-1];
    a_mag     = sign1 ? ('0 - op1) : op1;
    b_mag     = sign2 ? ('0 - op2) : op2;
    is_mul    = ~bus.op_i[2];
    div_zero  = (op2 == '0);
    div_ovf   = bus.op_i[2] & ~bus.op_i[0] &
                (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);
    prod_full = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  end

  // Iterative datapath: shift-add multiply step and sign fix-up values.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, prod_q[XLEN-1:1]};
    prod_fix = neg_q ? ('0 - mul_next) : mul_next;
    quo_fix  = neg_q ? ('0 - quo_nx) : quo_nx;
    rem_mag  = XLEN'(rem_nx);
    rem_fix  = neg_rem_q ? ('0 - rem_mag) : rem_mag;
  end

  // Next-state and hold logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_addr_d = rd_addr_q;
    b_d       = b_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    hold      = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          hold      = 1'b1;
          op_d      = bus.op_i;
          rd_addr_d = bus.rd_addr_i;
          b_d       = b_mag;
          neg_d     = sign1 ^ sign2;
          neg_rem_d = sign1;
          cnt_d     = CW'(XLEN-1);
          if (is_mul) begin
            if (MUL_ITER == 0) begin
              prod_d  = (sign1 ^ sign2) ? ('0 - prod_full) : prod_full;
              state_d = MD_DONE;
            end else begin
              prod_d  = {{XLEN{1'b0}}, a_mag};
              state_d = MD_CALC;
            end
          end else if (div_zero) begin
            quo_d   = '1;
            rem_d   = {1'b0, op1};
            state_d = MD_DONE;
          end else if (div_ovf) begin
            quo_d   = op1;
            rem_d   = '0;
            state_d = MD_DONE;
          end else begin
            // Dividend magnitude is shifted out of the quotient register.
            quo_d   = a_mag;
            rem_d   = '0;
            state_d = MD_CALC;
          end
        end
      end

      MD_CALC: begin
        hold  = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          if (!op_q[2]) begin
            prod_d = prod_fix;
          end else begin
            quo_d = quo_fix;
            rem_d = {1'b0, rem_fix};
          end
          state_d = MD_DONE;
        end else if (!op_q[2]) begin
          prod_d = mul_next;
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
        end
        if (bus.flush_i) begin
          state_d = MD_IDLE;
        end
      end

      MD_DONE: begin
        state_d = MD_IDLE;
      end

      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_comb begin
    unique case (op_q)
      INST_MUL:                         result = prod_q[XLEN-1:0];
      INST_MULH, INST_MULHSU,
      INST_MULHU:                       result = prod_q[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:              result = quo_q;
      default:                          result = rem_q[XLEN-1:0];
    endcase
  end

  // Write-back is driven straight from the DONE state, so a flush there
  // cannot suppress the already-committed pulse.
  always_comb begin
    bus.hold_flag_o = hold;
    bus.busy_o      = (state_q != MD_IDLE);
    bus.rd_wen_o    = (state_q == MD_DONE);
    bus.rd_addr_o   = (state_q == MD_DONE) ? rd_addr_q : '0;
    bus.rd_data_o   = (state_q == MD_DONE) ? result : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MD_IDLE;
      op_q      <= '0;
      rd_addr_q <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_addr_q <= rd_addr_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed bench for ex_muldiv. Two instances share one
// stimulus: u_dut0 with single-cycle multiply, u_dut1 with iterative multiply.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32), .REG_AW(5)) if0 ();
  ex_muldiv_if #(.XLEN(32), .REG_AW(5)) if1 ();

  assign if0.start_i = start;  assign if1.start_i = start;
  assign if0.op_i = op;        assign if1.op_i = op;
  assign if0.op1_i = a;        assign if1.op1_i = a;
  assign if0.op2_i = b;        assign if1.op2_i = b;
  assign if0.rd_addr_i = rd;   assign if1.rd_addr_i = rd;
  assign if0.flush_i = flush;  assign if1.flush_i = flush;

  ex_muldiv #(.XLEN(32), .MUL_ITER(0), .REG_AW(5)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  ex_muldiv #(.XLEN(32), .MUL_ITER(1), .REG_AW(5)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-back monitor, sampled just after the falling edge.
  int          pulses [2];
  int          holds  [2];
  int          lcyc   [2];
  logic [31:0] ldata  [2];
  logic [4:0]  laddr  [2];
  int          zviol = 0;

  task automatic sample(input int k, input logic wen, input logic hold,
                        input logic [31:0] d, input logic [4:0] ad);
    if (wen) begin
      pulses[k]++;
      lcyc[k]  = cyc;
      ldata[k] = d;
      laddr[k] = ad;
    end else if (d != '0 || ad != '0) begin
      zviol++;
    end
    if (hold) holds[k]++;
  endtask

  always @(negedge clk) begin
    #2;
    sample(0, if0.rd_wen_o, if0.hold_flag_o, if0.rd_data_o, if0.rd_addr_o);
    sample(1, if1.rd_wen_o, if1.hold_flag_o, if1.rd_data_o, if1.rd_addr_o);
  end

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      pulses[k] = 0; holds[k] = 0; lcyc[k] = -1; ldata[k] = '0; laddr[k] = '0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat0;
    int          lat1;
  } vec_t;

  vec_t vecs[$];

  // Issue one op at cycle N; returns N.
  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] r, output int n);
    @(negedge clk);
    clear_mon();
    n = cyc;
    start = 1'b1; op = o; a = x; b = y; rd = r;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int lat;
    issue(v.op, v.a, v.b, v.rd, n);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? v.lat0 : v.lat1;
      chk($sformatf("v%0d.dut%0d.pulses", idx, k), 64'(pulses[k]), 64'd1);
      chk($sformatf("v%0d.dut%0d.data", idx, k), 64'(ldata[k]), 64'(v.exp));
      chk($sformatf("v%0d.dut%0d.addr", idx, k), 64'(laddr[k]), 64'(v.rd));
      chk($sformatf("v%0d.dut%0d.latency", idx, k), 64'(lcyc[k] - n), 64'(lat));
      chk($sformatf("v%0d.dut%0d.hold_cycles", idx, k), 64'(holds[k]), 64'(lat));
    end
  endtask

  initial begin
    int n;

    vecs.push_back('{INST_DIVU,   32'd100,        32'd7,          5'd5,  32'd14,         33, 33});
    vecs.push_back('{INST_REMU,   32'd100,        32'd7,          5'd5,  32'd2,          33, 33});
    vecs.push_back('{INST_DIV,    32'hFFFF_FF9C,  32'd7,          5'd7,  32'hFFFF_FFF2,  33, 33});
    vecs.push_back('{INST_REM,    32'hFFFF_FF9C,  32'd7,          5'd8,  32'hFFFF_FFFE,  33, 33});
    vecs.push_back('{INST_DIV,    32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,  33, 33});
    vecs.push_back('{INST_REM,    32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1,          33, 33});
    vecs.push_back('{INST_DIV,    32'h1234,       32'd0,          5'd11, 32'hFFFF_FFFF,  1,  1});
    vecs.push_back('{INST_REM,    32'h1234,       32'd0,          5'd12, 32'h1234,       1,  1});
    vecs.push_back('{INST_DIVU,   32'h55,         32'd0,          5'd13, 32'hFFFF_FFFF,  1,  1});
    vecs.push_back('{INST_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000,  1,  1});
    vecs.push_back('{INST_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          1,  1});
    vecs.push_back('{INST_DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          33, 33});
    vecs.push_back('{INST_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd17, 32'h0000_0001,  1,  33});
    vecs.push_back('{INST_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd18, 32'h0000_0000,  1,  33});
    vecs.push_back('{INST_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd19, 32'hFFFF_FFFE,  1,  33});
    vecs.push_back('{INST_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd20, 32'hFFFF_FFFF,  1,  33});
    vecs.push_back('{INST_MUL,    32'h1234_5678,  32'h10,         5'd21, 32'h2345_6780,  1,  33});
    vecs.push_back('{INST_MULH,   32'h8000_0000,  32'h8000_0000,  5'd22, 32'h4000_0000,  1,  33});
    vecs.push_back('{INST_MULH,   32'h8000_0000,  32'd7,          5'd23, 32'hFFFF_FFFC,  1,  33});

    clear_mon();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("reset.dut0", {if0.busy_o, if0.hold_flag_o, if0.rd_wen_o, if0.rd_addr_o, if0.rd_data_o}, '0);
    chk("reset.dut1", {if1.busy_o, if1.hold_flag_o, if1.rd_wen_o, if1.rd_addr_o, if1.rd_data_o}, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Flush in cycle N+10 of a DIVU: no write-back, idle from N+11.
    issue(INST_DIVU, 32'd100, 32'd7, 5'd5, n);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush.busy.dut0", 64'(if0.busy_o), 64'd0);
    chk("flush.busy.dut1", 64'(if1.busy_o), 64'd0);
    repeat (40) @(negedge clk);
    #3;
    chk("flush.pulses.dut0", 64'(pulses[0]), 64'd0);
    chk("flush.pulses.dut1", 64'(pulses[1]), 64'd0);

    // Reset pulsed mid-CALC.
    issue(INST_DIVU, 32'd100, 32'd7, 5'd5, n);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    #1;
    chk("calc.busy.dut1", 64'(if1.busy_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst.dut0", {if0.busy_o, if0.hold_flag_o, if0.rd_wen_o, if0.rd_addr_o, if0.rd_data_o}, '0);
    chk("midrst.dut1", {if1.busy_o, if1.hold_flag_o, if1.rd_wen_o, if1.rd_addr_o, if1.rd_data_o}, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #3;
    chk("midrst.pulses.dut0", 64'(pulses[0]), 64'd0);
    chk("midrst.pulses.dut1", 64'(pulses[1]), 64'd0);

    // start together with flush in IDLE is ignored.
    @(negedge clk);
    clear_mon();
    start = 1'b1; flush = 1'b1; op = INST_DIVU; a = 32'd9; b = 32'd3; rd = 5'd4;
    #1;
    chk("startflush.hold.dut0", 64'(if0.hold_flag_o), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("startflush.busy.dut0", 64'(if0.busy_o), 64'd0);
    chk("startflush.busy.dut1", 64'(if1.busy_o), 64'd0);
    repeat (40) @(negedge clk);
    #3;
    chk("startflush.pulses.dut0", 64'(pulses[0]), 64'd0);

    // Flush in DONE still produces the committed pulse.
    issue(INST_MUL, 32'd6, 32'd7, 5'd3, n);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    #1;
    chk("doneflush.wen.dut0", 64'(if0.rd_wen_o), 64'd1);
    chk("doneflush.data.dut0", 64'(if0.rd_data_o), 64'd42);
    chk("doneflush.hold.dut0", 64'(if0.hold_flag_o), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("doneflush.busy.dut0", 64'(if0.busy_o), 64'd0);
    chk("doneflush.busy.dut1", 64'(if1.busy_o), 64'd0);
    repeat (40) @(negedge clk);
    #3;
    chk("doneflush.pulses.dut0", 64'(pulses[0]), 64'd1);
    chk("doneflush.pulses.dut1", 64'(pulses[1]), 64'd0);

    // Back-to-back: second start raised in DONE, held into the IDLE cycle.
    issue(INST_DIVU, 32'd100, 32'd7, 5'd5, n);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    start = 1'b1; op = INST_REMU; rd = 5'd6;
    #1;
    chk("b2b.first.wen.dut0", 64'(if0.rd_wen_o), 64'd1);
    chk("b2b.first.data.dut0", 64'(if0.rd_data_o), 64'd14);
    chk("b2b.first.addr.dut1", 64'(if1.rd_addr_o), 64'd5);
    chk("b2b.done.hold.dut1", 64'(if1.hold_flag_o), 64'd0);
    @(negedge clk);
    #1;
    chk("b2b.idle.busy.dut1", 64'(if1.busy_o), 64'd0);
    chk("b2b.idle.hold.dut1", 64'(if1.hold_flag_o), 64'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("b2b.pulses.dut%0d", k), 64'(pulses[k]), 64'd2);
      chk($sformatf("b2b.data.dut%0d", k), 64'(ldata[k]), 64'd2);
      chk($sformatf("b2b.addr.dut%0d", k), 64'(laddr[k]), 64'd6);
      chk($sformatf("b2b.latency.dut%0d", k), 64'(lcyc[k] - n), 64'd67);
    end

    // start pulsed during CALC is ignored.
    issue(INST_DIVU, 32'd100, 32'd7, 5'd5, n);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 5) begin
        start = 1'b1; op = INST_MUL; a = 32'd3; b = 32'd3; rd = 5'd9;
      end
      if (i == 6) start = 1'b0;
    end
    repeat (40) @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("calcstart.pulses.dut%0d", k), 64'(pulses[k]), 64'd1);
      chk($sformatf("calcstart.data.dut%0d", k), 64'(ldata[k]), 64'd14);
      chk($sformatf("calcstart.addr.dut%0d", k), 64'(laddr[k]), 64'd5);
      chk($sformatf("calcstart.latency.dut%0d", k), 64'(lcyc[k] - n), 64'd33);
    end

    chk("outputs_zero_outside_done", 64'(zviol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
